// File: rtl/out_uart_tx.sv
// Byte-output FIFO feeding an 8N1 UART transmitter with sticky overflow.
// Define OUT_UART_PARITY_EN to add an even-parity bit to each frame.
module out_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic [CNT_W-1:0] level,
    output logic             overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(FIFO_DEPTH);

`ifdef OUT_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CNT_W-1:0] level_nxt;
    state_t           state;
    logic [BW-1:0]    baud;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef OUT_UART_PARITY_EN
    logic             par;
`endif
    logic             push;
    logic             pop;
    logic             bit_end;

    always_comb begin
        push      = in_valid && !full;
        bit_end   = (baud == BAUD_MAX);
        pop       = (level != '0) &&
                    ((state == IDLE) || ((state == STOP) && bit_end));
        level_nxt = level;
        if (push && !pop)
            level_nxt = level + CNT_W'(1);
        else if (pop && !push)
            level_nxt = level - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LVL_FULL);
            // full is the pre-edge value, so a same-edge pop cannot save the byte
            if (in_valid && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef OUT_UART_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (state == IDLE || bit_end)
                baud <= '0;
            else
                baud <= baud + BW'(1);

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        shift <= mem[rptr];
`ifdef OUT_UART_PARITY_EN
                        par   <= ^mem[rptr];
`endif
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
                            state <= PARITY;
                            tx    <= par;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end
                end
`ifdef OUT_UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        // chain straight into the next frame when data waits
                        if (pop) begin
                            shift <= mem[rptr];
`ifdef OUT_UART_PARITY_EN
                            par   <= ^mem[rptr];
`endif
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/out_uart_tx.md
Name: out_uart_tx

Overview:
- Downstream consumer of the CPU byte output port (out / outOn) in top.
- Each byte is captured on its valid strobe, queued in a small FIFO, and serialized as 8N1 UART frames on a single tx pin.
- Lets the CPU emit bytes back-to-back (OUT imm8, OUT reg:reg) faster than the serial line drains them, with overflow reported instead of silently lost.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range >= 2.
- FIFO_DEPTH, 8, byte entries; power of two, >= 2.
- CNT_W, 4, width of level output; must be log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_data  input  8  byte from CPU out.
- in_valid  input  1  byte strobe; sampled at rising clk edge.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is on the line (state != IDLE).
- full  output  1  FIFO level == FIFO_DEPTH.
- level  output  CNT_W  current FIFO occupancy.
- overflow  output  1  sticky; a byte was dropped because FIFO was full.

Behaviour:
- Reset (reset low, asynchronous): tx=1, busy=0, full=0, level=0, overflow=0; FIFO pointers cleared; FSM to IDLE; bit and baud counters = 0.
- Reset mid-frame truncates the frame immediately: tx=1, and the queued bytes are discarded.
- Push:
  - At a rising edge with in_valid=1 and full=0 (pre-edge value), in_data is written at the write pointer and wptr increments.
  - Pointers wrap modulo FIFO_DEPTH.
- Drop:
  - in_valid=1 with full=1 (pre-edge) drops the byte and sets overflow.
  - This holds even if a pop occurs on the same edge.
  - overflow clears only on reset.
- Simultaneous push and pop (not full): level unchanged, both pointers advance.
- Level: push-only +1, pop-only -1, both 0.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled).
  - IDLE: tx=1. If level != 0 at an edge, pop the head byte into the shift register, clear the baud counter, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx = shift[0], LSB first.
    - Every CLKS_PER_BIT cycles, shift right and increment the bit index.
    - After bit 7 completes, go to STOP (or PARITY).
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end:
    - if level != 0, pop and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Latency: push at edge N into an empty FIFO while IDLE gives pop and START at edge N+1. tx falls after edge N+1.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- tx, busy and full are registered outputs (no combinational path from in_valid).
- in_valid held high for k cycles pushes k bytes. The producer must pulse it for exactly one sampled edge per byte.

Optional Feature:
- Macro OUT_UART_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11 bits.
- Undefined: no PARITY state, no parity logic; frame is 10 bits.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, CNT_W=3, parity off unless noted):
- Reset, then push 0xA5 once:
  - tx low from edge 1 after the push for 4 cycles;
  - then 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles;
  - busy high for exactly 40 cycles; level returns to 0 at the pop edge.
- Push 0x01, 0x02, 0x03 on consecutive edges:
  - three frames back-to-back with no idle between the STOP of one and the START of the next;
  - level sequence 1,1,2,... down to 0;
  - decoded bytes 01,02,03.
- Push 6 bytes on consecutive edges while the first frame starts:
  - 1 byte popped, 4 queued, full=1;
  - 6th byte dropped, overflow=1 and stays 1 after all frames finish;
  - 5 bytes transmitted in order.
- Full FIFO, pop at STOP end on the same edge as in_valid=1: byte dropped, overflow=1, level goes 4 -> 3.
- Assert reset low mid-DATA of 0xFF with 2 bytes queued: tx=1 and level=0 immediately (no clock); after release, tx stays 1 and busy=0.
- With OUT_UART_PARITY_EN, push 0x07: parity bit = 1, frame 44 cycles. Push 0x03: parity bit = 0.
